// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl: burst sequencer that owns IN/SV/en of one XorOp; `KEY_ROTATE_EN rotates the key per byte.
// Latency: input handshake -> out_valid two clocks later; peak one byte per three cycles.
// Backpressure: in_ready only in ACCEPT; the result is held in EMIT until out_ready.
module xor_cipher_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] xor_in,
  output logic [WIDTH-1:0] xor_sv,
  output logic             xor_en,
  input  logic [WIDTH-1:0] xor_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] xor_in_q, xor_in_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_ready_q, in_ready_d;
  logic             xor_en_q, xor_en_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] cnt_inc;
  logic             last_byte;
  logic             in_hs;
  logic             out_hs;

  assign cnt_inc   = byte_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
  assign last_byte = (cnt_inc == len_q);
  assign in_hs     = (state_q == ST_ACCEPT) && in_valid;
  assign out_hs    = (state_q == ST_EMIT) && out_ready;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    xor_in_d   = xor_in_q;
    out_data_d = out_data_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          key_d = key_in;
        end
        if (start) begin
          len_d      = len;
          byte_cnt_d = '0;
          state_d    = (len == '0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_hs) begin
          xor_in_d = in_data;
          state_d  = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        // XorOp is combinational and enabled only in this state.
        out_data_d = xor_out;
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_hs) begin
          byte_cnt_d = cnt_inc;
`ifdef KEY_ROTATE_EN
          key_d = {key_q[WIDTH-2:0], key_q[WIDTH-1]};
`else
          key_d = key_q;
`endif
          state_d = last_byte ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status strobes are registered off the next state so they are glitch-free at the pins.
  always_comb begin
    in_ready_d  = (state_d == ST_ACCEPT);
    xor_en_d    = (state_d == ST_COMPUTE);
    out_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      xor_in_q    <= '0;
      out_data_q  <= '0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      xor_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      xor_in_q    <= xor_in_d;
      out_data_q  <= out_data_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      xor_en_q    <= xor_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign xor_in    = xor_in_q;
  assign xor_sv    = key_q;
  assign xor_en    = xor_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Bench for xor_cipher_ctrl: XorOp stand-in, negedge monitor, and a per-burst reference model.
module tb_xor_cipher_ctrl;
  localparam int WIDTH = 8;
  localparam int LEN_W = 5;
`ifdef KEY_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_load = 1'b0;
  logic [WIDTH-1:0] key_in = '0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready, xor_en, out_valid, busy, done;
  logic [WIDTH-1:0] xor_in, xor_sv, xor_out, out_data;
  logic [LEN_W-1:0] byte_cnt;

  xor_cipher_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .xor_in(xor_in), .xor_sv(xor_sv), .xor_en(xor_en),
    .xor_out(xor_out), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // The XorOp instance: output is forced to zero while disabled.
  assign xor_out = xor_en ? (xor_in ^ xor_sv) : 8'h00;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_total = 0, done_total = 0, busy_total = 0, inrdy_total = 0;
  int lat_bad = 0, lat_seen = 0, hs_cyc = 0;
  bit ov_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (xor_en) en_total++;
      if (done) done_total++;
      if (busy) busy_total++;
      if (in_ready) inrdy_total++;
      if (out_valid && !ov_prev) begin
        lat_seen++;
        if (cyc - hs_cyc != 2) lat_bad++;
      end
      if (in_valid && in_ready) hs_cyc = cyc;
      if (out_valid && out_ready) got_q.push_back(out_data);
      ov_prev = out_valid;
    end
  end

  logic [7:0] model_key = 8'h00;
  logic [7:0] bdata[32];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] rotl(input logic [7:0] k);
    return {k[6:0], k[7]};
  endfunction

  task automatic model_burst(input bit do_load, input logic [7:0] k, input logic [4:0] n);
    exp_q.delete();
    if (do_load) model_key = k;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(bdata[i] ^ model_key);
      if (ROT) model_key = rotl(model_key);
    end
  endtask

  task automatic run_burst(input bit do_load, input logic [7:0] k, input logic [4:0] n,
                           input int stall, input bit pulse_mid,
                           output bit got_done, output logic [4:0] cnt_at_done);
    int idx;
    int budget;
    bit pulse_pending;
    idx = 0;
    got_done = 1'b0;
    cnt_at_done = '0;
    pulse_pending = pulse_mid;
    budget = 200 + 40 * int'(n);
    @(posedge clk); #1;
    key_load = do_load; key_in = k; start = 1'b1; len = n;
    for (int c = 0; c < budget && !got_done; c++) begin
      @(posedge clk); #1;
      key_load = 1'b0; start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        cnt_at_done = byte_cnt;
      end else begin
        if (pulse_pending && idx == 1 && idx < int'(n) && busy) begin
          start = 1'b1; key_load = 1'b1; key_in = ~k; len = 5'(n + 5'd3);
          pulse_pending = 1'b0;
        end
        in_valid = ($urandom_range(99) >= stall) && (idx < int'(n));
        in_data = in_valid ? bdata[idx] : 8'($urandom);
        if (in_valid && in_ready) idx++;
        out_ready = ($urandom_range(99) >= stall);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int d0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, xor_en, out_valid, busy, done} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, xor_en, out_valid, busy, done});
    end
    checks++;
    if ({xor_in, xor_sv, out_data, byte_cnt} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", xor_in, xor_sv, out_data, byte_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    // Reset mid-EMIT
    @(posedge clk); #1;
    key_load = 1'b1; key_in = 8'h3C; start = 1'b1; len = 5'd2;
    @(posedge clk); #1;
    key_load = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h2D) begin
      failures++; $display("FAIL pre_reset_emit got=%b/%h exp=1/2d", out_valid, out_data);
    end
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, xor_en, out_valid, busy, done} !== 5'b0 ||
        {xor_in, xor_sv, out_data, byte_cnt} !== '0) begin
      failures++;
      $display("FAIL midburst_reset got=%b %h/%h/%h/%h exp=all zero",
               {in_ready, xor_en, out_valid, busy, done}, xor_in, xor_sv, out_data, byte_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    model_key = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_total != d0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_no_done got=%0d busy=%b exp=%0d busy=0", done_total, busy, d0);
    end
  endtask

  task automatic test_basic();
    int base, e0, d0;
    bit gd;
    logic [4:0] cnt;
    bdata[0] = 8'h00; bdata[1] = 8'hFF; bdata[2] = 8'h5A;
    model_burst(1'b1, 8'hA5, 5'd3);
    base = got_q.size(); e0 = en_total; d0 = done_total;
    run_burst(1'b1, 8'hA5, 5'd3, 0, 1'b0, gd, cnt);
    checks++;
    if (!gd || cnt !== 5'd3) begin
      failures++; $display("FAIL basic_done got=%b cnt=%0d exp=1 cnt=3", gd, cnt);
    end
    checks++;
    if (got_q.size() - base != 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", got_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[base+i] !== exp_q[i]) begin
          failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (!ROT && (exp_q[0] !== 8'hA5 || exp_q[1] !== 8'h5A || exp_q[2] !== 8'hFF || got_q[base+1] !== 8'h5A)) begin
      failures++; $display("FAIL basic_const got=%h exp=5a", got_q[base+1]);
    end
    checks++;
    if (en_total - e0 != 3 || done_total - d0 != 1) begin
      failures++; $display("FAIL basic_strobes en=%0d done=%0d exp=3/1", en_total - e0, done_total - d0);
    end
    checks++;
    if (byte_cnt !== 5'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_hold got=%0d busy=%b exp=3 busy=0", byte_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int c;
    bdata[0] = 8'($urandom);
    model_burst(1'b0, 8'h00, 5'd1);
    base = got_q.size();
    @(posedge clk); #1;
    start = 1'b1; len = 5'd1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = bdata[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 10) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (!out_valid) begin
      failures++; $display("FAIL bp_reach_emit got=0 exp=1");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0] || in_ready !== 1'b0 || xor_en !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b d%h r%b e%b exp=v1 d%h r0 e0", i, out_valid, out_data, in_ready, xor_en, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    c = 0;
    while (!done && c < 10) begin
      @(posedge clk); #1; c++;
    end
    out_ready = 1'b0;
    checks++;
    if (!done || got_q.size() - base != 1 || got_q[got_q.size()-1] !== exp_q[0]) begin
      failures++; $display("FAIL bp_release got=done%b n%0d exp=done1 n1 d%h", done, got_q.size() - base, exp_q[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero();
    int b0, d0, r0, e0;
    bit gd;
    logic [4:0] cnt;
    b0 = busy_total; d0 = done_total; r0 = inrdy_total; e0 = en_total;
    run_burst(1'b0, 8'h00, 5'd0, 0, 1'b0, gd, cnt);
    checks++;
    if (!gd || cnt !== 5'd0) begin
      failures++; $display("FAIL len0_done got=%b cnt=%0d exp=1 cnt=0", gd, cnt);
    end
    checks++;
    if (busy_total - b0 != 1 || done_total - d0 != 1 || inrdy_total != r0 || en_total != e0) begin
      failures++;
      $display("FAIL len0_strobes busy=%0d done=%0d rdy=%0d en=%0d exp=1/1/0/0",
               busy_total - b0, done_total - d0, inrdy_total - r0, en_total - e0);
    end
  endtask

  task automatic test_ignore_midburst();
    int base, d0;
    bit gd;
    logic [4:0] cnt;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) bdata[i] = 8'($urandom);
      model_burst(pass == 0, 8'h6E, 5'd4);
      base = got_q.size(); d0 = done_total;
      run_burst(pass == 0, 8'h6E, 5'd4, 20, pass == 0, gd, cnt);
      checks++;
      if (!gd || cnt !== 5'd4 || done_total - d0 != 1 || got_q.size() - base != 4) begin
        failures++; $display("FAIL ignore%0d_len got=%b cnt=%0d n=%0d exp=1 cnt=4 n=4", pass, gd, cnt, got_q.size() - base);
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (got_q[base+i] !== exp_q[i]) begin
            failures++; $display("FAIL ignore%0d_byte%0d got=%h exp=%h", pass, i, got_q[base+i], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_rotate();
    int base;
    bit gd;
    logic [4:0] cnt;
    bdata[0] = 8'h00; bdata[1] = 8'h00;
    model_burst(1'b1, 8'h81, 5'd2);
    base = got_q.size();
    run_burst(1'b1, 8'h81, 5'd2, 0, 1'b0, gd, cnt);
    checks++;
    if (!gd || got_q.size() - base != 2) begin
      failures++; $display("FAIL rotate_count got=%0d exp=2", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== 8'h81 || got_q[base+1] !== (ROT ? 8'h03 : 8'h81)) begin
        failures++;
        $display("FAIL rotate_bytes got=%h,%h exp=81,%h", got_q[base], got_q[base+1], ROT ? 8'h03 : 8'h81);
      end
    end
  endtask

  task automatic test_random();
    int base, d0, e0;
    bit gd, ld;
    logic [4:0] n;
    logic [7:0] k;
    for (int b = 0; b < 8; b++) begin
      n = (b == 7) ? 5'd31 : 5'($urandom_range(10));
      ld = (b == 0) || ($urandom_range(1) == 1);
      k = 8'($urandom);
      for (int i = 0; i < 32; i++) bdata[i] = 8'($urandom);
      model_burst(ld, k, n);
      base = got_q.size(); d0 = done_total; e0 = en_total;
      run_burst(ld, k, n, 30, 1'b0, gd, n);
      checks++;
      if (!gd || got_q.size() - base != exp_q.size() || int'(n) != exp_q.size() ||
          done_total - d0 != 1 || en_total - e0 != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_len got=done%b n%0d cnt%0d en%0d exp=n%0d", b, gd, got_q.size() - base, n, en_total - e0, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[base+i] !== exp_q[i]) begin
            failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", b, i, got_q[base+i], exp_q[i]);
          end
        end
      end
    end
    checks++;
    if (lat_bad != 0 || lat_seen == 0) begin
      failures++; $display("FAIL latency got=%0d bad of %0d exp=0 bad", lat_bad, lat_seen);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_ignore_midburst();
    test_rotate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
